// File: rtl/row_load_cmd_parser.sv
// Row-load command decoder: turns a UART byte stream of 'L', row, {hi,lo} x N into
// framebuffer pixel writes, with row completion and abort (framing/timeout) pulses.
module row_load_cmd_parser #(
  parameter int unsigned ROW_WIDTH      = 5,
  parameter int unsigned COL_WIDTH      = 6,
  parameter int unsigned PIXELS_PER_ROW = 64,
  parameter logic [7:0]  CMD_BYTE       = 8'h4C,
  parameter int unsigned TIMEOUT_TICKS  = 10000,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [ROW_WIDTH+COL_WIDTH-1:0] ram_write_addr,
  output logic [15:0]                    ram_write_data,
  output logic                           ram_write_enable,
  output logic                           row_done,
  output logic                           busy,
  output logic                           frame_error
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRow   = 2'd1;
  localparam logic [1:0] StPixHi = 2'd2;
  localparam logic [1:0] StPixLo = 2'd3;

  localparam logic [COL_WIDTH-1:0]     LastCol   = COL_WIDTH'(PIXELS_PER_ROW - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TermCount = TIMEOUT_WIDTH'(TIMEOUT_TICKS - 1);

  logic [1:0]                     state_q, state_d;
  logic [ROW_WIDTH-1:0]           row_q, row_d;
  logic [COL_WIDTH-1:0]           col_q, col_d;
  logic [7:0]                     hi_q, hi_d;
  logic [TIMEOUT_WIDTH-1:0]       timer_q, timer_d;
  logic [ROW_WIDTH+COL_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]                    data_q, data_d;
  logic                           we_q, we_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;

  logic row_bad;
  logic timeout_hit;

  assign row_bad = (rx_data >> ROW_WIDTH) != 8'd0;

  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign timeout_hit = (state_q != StIdle) && !rx_valid && (timer_q == TermCount);

  always_comb begin
    timer_d = timer_q + TIMEOUT_WIDTH'(1);
    if (state_q == StIdle || rx_valid) begin
      timer_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == CMD_BYTE) begin
          state_d = StRow;
        end
      end
      StRow: begin
        if (rx_valid) begin
          if (row_bad) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            row_d   = rx_data[ROW_WIDTH-1:0];
            col_d   = '0;
            state_d = StPixHi;
          end
        end
      end
      StPixHi: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = StPixLo;
        end
      end
      StPixLo: begin
        if (rx_valid) begin
          addr_d = {row_q, col_q};
          data_d = {hi_q, rx_data};
          we_d   = 1'b1;
          if (col_q == LastCol) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            col_d   = col_q + COL_WIDTH'(1);
            state_d = StPixHi;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort drops any half-received pixel; no write is issued.
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      hi_q    <= '0;
      timer_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hi_q    <= hi_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ram_write_addr   = addr_q;
  assign ram_write_data   = data_q;
  assign ram_write_enable = we_q;
  assign row_done         = done_q;
  assign frame_error      = err_q;
  assign busy             = state_q != StIdle;

endmodule

// File: tb/tb_row_load_cmd_parser.sv
// Bench for row_load_cmd_parser: byte streams are built from command contents and the
// expected pixel writes are derived directly from row/column arithmetic.
module tb_row_load_cmd_parser;

  localparam int unsigned TICKS = 10000;
  localparam int unsigned PPR   = 64;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] ram_write_addr;
  logic [15:0] ram_write_data;
  logic        ram_write_enable;
  logic        row_done;
  logic        busy;
  logic        frame_error;

  row_load_cmd_parser #(
    .TIMEOUT_TICKS (TICKS)
  ) dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .ram_write_addr   (ram_write_addr),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .row_done         (row_done),
    .busy             (busy),
    .frame_error      (frame_error)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  b;
    int          gap;
    bit          is_lo;
    logic [10:0] addr;
    logic [15:0] data;
    bit          last;
  } tx_t;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    int          cyc;
    bit          done;
  } wr_t;

  tx_t         stream[$];
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [15:0] pix[PPR];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_seen = 0;
  int stray_done = 0;
  int obs_rd = 0;
  int err_base = 0;
  int stray_base = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    wr_t w;
    if (ram_write_enable) begin
      w.addr = ram_write_addr;
      w.data = ram_write_data;
      w.cyc  = cyc;
      w.done = row_done;
      obs_q.push_back(w);
    end
    if (row_done && !ram_write_enable) stray_done = stray_done + 1;
    if (frame_error) err_seen = err_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input int gap);
    tx_t t;
    t.b = b; t.gap = gap; t.is_lo = 1'b0; t.addr = '0; t.data = '0; t.last = 1'b0;
    stream.push_back(t);
  endtask

  // Load command for `row` carrying pix[0..npix-1]; gaps drawn from 0..gmax.
  task automatic add_load(input int row, input int npix, input int gmax);
    tx_t t;
    add_byte(8'h4C, $urandom_range(0, gmax));
    add_byte(8'(row), $urandom_range(0, gmax));
    for (int n = 0; n < npix; n++) begin
      add_byte(pix[n][15:8], $urandom_range(0, gmax));
      t.b = pix[n][7:0]; t.gap = $urandom_range(0, gmax); t.is_lo = 1'b1;
      t.addr = 11'(row * PPR + n); t.data = pix[n]; t.last = (n == PPR - 1);
      stream.push_back(t);
    end
  endtask

  task automatic run_stream();
    wr_t w;
    foreach (stream[i]) begin
      rx_valid = 1'b0;
      repeat (stream[i].gap) begin @(posedge clk_in); #1; end
      rx_valid = 1'b1;
      rx_data  = stream[i].b;
      if (stream[i].is_lo) begin
        w.addr = stream[i].addr; w.data = stream[i].data;
        w.cyc = cyc + 1; w.done = stream[i].last;
        exp_q.push_back(w);
      end
      @(posedge clk_in); #1;
    end
    rx_valid = 1'b0;
    stream.delete();
  endtask

  task automatic compare_writes(input string tag, input int exp_errs);
    int nobs;
    int n;
    repeat (3) begin @(posedge clk_in); #1; end
    nobs = obs_q.size() - obs_rd;
    check({tag, " write count"}, 32'(nobs), 32'(exp_q.size()));
    n = (nobs < exp_q.size()) ? nobs : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " addr"}, 32'(obs_q[obs_rd + i].addr), 32'(exp_q[i].addr));
      check({tag, " data"}, 32'(obs_q[obs_rd + i].data), 32'(exp_q[i].data));
      check({tag, " latency"}, 32'(obs_q[obs_rd + i].cyc), 32'(exp_q[i].cyc));
      check({tag, " row_done"}, 32'(obs_q[obs_rd + i].done), 32'(exp_q[i].done));
    end
    check({tag, " frame_error"}, 32'(err_seen - err_base), 32'(exp_errs));
    check({tag, " stray row_done"}, 32'(stray_done - stray_base), 32'd0);
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    obs_rd     = obs_q.size();
    err_base   = err_seen;
    stray_base = stray_done;
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " addr"}, 32'(ram_write_addr), 32'd0);
    check({tag, " data"}, 32'(ram_write_data), 32'd0);
    check({tag, " we"}, 32'(ram_write_enable), 32'd0);
    check({tag, " row_done"}, 32'(row_done), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " frame_error"}, 32'(frame_error), 32'd0);
  endtask

  initial begin
    logic [7:0] g;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) begin @(posedge clk_in); #1; end
    check_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clk_in); #1;

    // Nominal row 3, back-to-back bytes.
    for (int n = 0; n < PPR; n++) pix[n] = {8'(n), 8'hA5};
    add_load(3, PPR, 0);
    run_stream();
    compare_writes("nominal", 0);

    // Garbage before the opcode, opcode value inside the payload.
    add_byte(8'h00, 0);
    add_byte(8'hFF, 1);
    pix[0] = 16'h4C4C;
    for (int n = 1; n < PPR; n++) pix[n] = 16'($urandom);
    add_load(31, PPR, 1);
    run_stream();
    compare_writes("garbage+opcode payload", 0);

    // Bad row byte, then a normal load of row 0.
    add_byte(8'h4C, 0);
    add_byte(8'h20, 0);
    run_stream();
    compare_writes("bad row", 1);
    for (int n = 0; n < PPR; n++) pix[n] = 16'($urandom);
    add_load(0, PPR, 2);
    run_stream();
    compare_writes("row0 after bad row", 0);

    // Timeout with a half-received pixel.
    add_byte(8'h4C, 0);
    add_byte(8'h05, 0);
    add_byte(8'h98, 0);
    run_stream();
    repeat (TICKS + 5) begin @(posedge clk_in); #1; end
    compare_writes("timeout", 1);
    for (int n = 0; n < PPR; n++) pix[n] = 16'($urandom);
    add_load(5, PPR, 1);
    run_stream();
    compare_writes("load after timeout", 0);

    // Bytes landing exactly on the terminal-count cycle (ROW->PIX_HI and PIX_HI->PIX_LO).
    for (int n = 0; n < PPR; n++) pix[n] = 16'($urandom);
    add_load(6, PPR, 0);
    stream[2].gap  = TICKS - 1;
    stream[13].gap = TICKS - 1;
    run_stream();
    compare_writes("timeout boundary", 0);

    // Reset after 10 pixels of row 7; leftover bytes must not write.
    for (int n = 0; n < PPR; n++) pix[n] = {8'(n), 8'h5A};
    add_load(7, 10, 0);
    run_stream();
    reset = 1'b1;
    @(posedge clk_in); #1;
    check_zero_outputs("mid-row reset");
    reset = 1'b0;
    compare_writes("pre-reset pixels", 0);
    for (int n = 10; n < PPR; n++) begin
      add_byte(pix[n][15:8], 0);
      add_byte(pix[n][7:0], 0);
    end
    run_stream();
    compare_writes("post-reset leftovers", 0);
    for (int n = 0; n < PPR; n++) pix[n] = 16'($urandom);
    add_load(7, PPR, 1);
    run_stream();
    compare_writes("row7 restart", 0);

    // Random rows, pixels, gaps and idle garbage; gap 0 exercises opcode right after row_done.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        do g = 8'($urandom); while (g == 8'h4C);
        add_byte(g, $urandom_range(0, 2));
      end
      for (int n = 0; n < PPR; n++) pix[n] = 16'($urandom);
      add_load(int'($urandom_range(0, 31)), PPR, 3);
      if (k % 2 == 1) stream[0].gap = 0;
      run_stream();
      compare_writes("random load", 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
